board_port_arbiter: RTL and testbench

Sequencer and arbiter for the control-clock port (port 1) of one `board_mem` instance. It shares the single read/write port between two requesters and owns a board-clear sweep. Requester A is the game FSM; requester B is the placement/validation logic. The clear sweep writes EMPTY to all 144 cells at game start. One instance sits in front of each board memory (my board, enemy board), all in the `control_clk` domain.

---
 rtl/board_pkg.sv | 20 ++
 rtl/board_sweep_ctr.sv | 54 +++++
 rtl/board_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_board_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board types and constants for the board memory arbiters.
package board_pkg;

  localparam int BOARD_X = 12;
  localparam int BOARD_Y = 12;

  typedef logic [1:0] cell_t;
  localparam cell_t EMPTY = 2'b00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_sel_e;

endpackage

// File: rtl/board_sweep_ctr.sv
// Row-major 2-D cell counter for the board-clear sweep; x wraps at X_SIZE, y at Y_SIZE.
// done_o flags that the counter currently sits on the last cell; nxt_addr_o is the following {y, x}.
module board_sweep_ctr #(
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int X_SIZE = 12,
  parameter int Y_SIZE = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                adv_i,
  output logic [YW+XW-1:0]    nxt_addr_o,
  output logic                done_o
);

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  logic [XW-1:0] x_q, x_d, x_nxt;
  logic [YW-1:0] y_q, y_d, y_nxt;

  always_comb begin
    x_nxt = x_q + 1'b1;
    y_nxt = y_q;
    if (x_q == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end
    x_d = x_q;
    y_d = y_q;
    if (start_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      x_d = x_nxt;
      y_d = y_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign nxt_addr_o = {y_nxt, x_nxt};
  assign done_o     = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/board_port_arbiter.sv
// Round-robin arbiter for board_mem port 1 between requesters A and B, plus the board-clear sweep.
// Grant one cycle after req, read data one cycle after grant; requests wait (req held) during a sweep.
module board_port_arbiter
  import board_pkg::*;
#(
  parameter int DATA_WIDTH   = 2,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int X_SIZE       = BOARD_X,
  parameter int Y_SIZE       = BOARD_Y
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear_req,
  output logic                                 clear_busy,
  output logic                                 clear_done,
  input  logic                                 a_req,
  input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]                a_wdata,
  input  logic                                 a_w_nr,
  output logic                                 a_gnt,
  output logic                                 a_rvalid,
  input  logic                                 b_req,
  input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]                b_wdata,
  input  logic                                 b_w_nr,
  output logic                                 b_gnt,
  output logic                                 b_rvalid,
  output logic [DATA_WIDTH-1:0]                rdata,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  output logic                                 mem_w_nr,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
);

  localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH;

  arb_state_e           state_q, state_d;
  req_sel_e             last_q, last_d;
  logic                 a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                 a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  logic                 clear_done_q, clear_done_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                 mem_w_nr_q, mem_w_nr_d;

  logic                 a_elig, b_elig, a_win, b_win;
  logic                 sweep_start, sweep_adv, sweep_done;
  logic [AW-1:0]        sweep_nxt;

  board_sweep_ctr #(
    .XW     (X_ADDR_WIDTH),
    .YW     (Y_ADDR_WIDTH),
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) u_sweep (
    .clk        (clk),
    .rst        (rst),
    .start_i    (sweep_start),
    .adv_i      (sweep_adv),
    .nxt_addr_o (sweep_nxt),
    .done_o     (sweep_done)
  );

  // A requester whose grant is showing this cycle sits out, so a held req is not granted twice.
  assign a_elig = a_req & ~a_gnt_q;
  assign b_elig = b_req & ~b_gnt_q;
  assign a_win  = a_elig & (~b_elig | (last_q == REQ_B));
  assign b_win  = b_elig & ~a_win;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_rv_d       = a_gnt_q & ~mem_w_nr_q;
    b_rv_d       = b_gnt_q & ~mem_w_nr_q;
    clear_done_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_w_nr_d   = 1'b0;
    sweep_start  = 1'b0;
    sweep_adv    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d     = ST_CLEAR;
          sweep_start = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = DATA_WIDTH'(EMPTY);
          mem_w_nr_d  = 1'b1;
        end else if (a_win) begin
          a_gnt_d     = 1'b1;
          last_d      = REQ_A;
          mem_addr_d  = a_addr;
          mem_wdata_d = a_wdata;
          mem_w_nr_d  = a_w_nr;
        end else if (b_win) begin
          b_gnt_d     = 1'b1;
          last_d      = REQ_B;
          mem_addr_d  = b_addr;
          mem_wdata_d = b_wdata;
          mem_w_nr_d  = b_w_nr;
        end
      end
      ST_CLEAR: begin
        if (sweep_done) begin
          state_d      = ST_IDLE;
          clear_done_d = 1'b1;
        end else begin
          sweep_adv   = 1'b1;
          mem_addr_d  = sweep_nxt;
          mem_wdata_d = DATA_WIDTH'(EMPTY);
          mem_w_nr_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_q       <= REQ_B;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rv_q       <= 1'b0;
      b_rv_q       <= 1'b0;
      clear_done_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_w_nr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rv_q       <= a_rv_d;
      b_rv_q       <= b_rv_d;
      clear_done_q <= clear_done_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_w_nr_q   <= mem_w_nr_d;
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = clear_done_q;
  assign a_gnt      = a_gnt_q;
  assign b_gnt      = b_gnt_q;
  assign a_rvalid   = a_rv_q;
  assign b_rvalid   = b_rv_q;
  assign rdata      = mem_rdata;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_w_nr   = mem_w_nr_q;

endmodule

// File: tb/tb_board_port_arbiter.sv
// Scoreboard bench for board_port_arbiter with a behavioural board_mem port model.
module tb_board_port_arbiter;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic       w;
    logic [1:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req;
  logic       clear_busy, clear_done;
  logic       a_req, a_w_nr, a_gnt, a_rvalid;
  logic [7:0] a_addr;
  logic [1:0] a_wdata;
  logic       b_req, b_w_nr, b_gnt, b_rvalid;
  logic [7:0] b_addr;
  logic [1:0] b_wdata;
  logic [1:0] rdata;
  logic [7:0] mem_addr;
  logic [1:0] mem_wdata;
  logic       mem_w_nr;
  logic [1:0] mem_rdata;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   loaded = 1'b0;
  logic [1:0] mem [256];

  exp_t q_ga[$], q_gb[$], q_ra[$], q_rb[$], q_cw[$], q_dn[$];

  board_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .a_req      (a_req),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_w_nr     (a_w_nr),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .b_req      (b_req),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_w_nr     (b_w_nr),
    .b_gnt      (b_gnt),
    .b_rvalid   (b_rvalid),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_w_nr   (mem_w_nr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Port model: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 2'b00;
      mem[8'h23] <= 2'b10;
      mem[8'h45] <= 2'b11;
      loaded     <= 1'b1;
    end else if (mem_w_nr) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void cmp(string nm, exp_t e, int acyc, logic [7:0] aaddr, logic aw, logic [1:0] adat);
    tests++;
    if (acyc != e.cyc || aaddr !== e.addr || aw !== e.w || adat !== e.dat) begin
      fails++;
      $display("FAIL %s: got cyc=%0d addr=%02h w=%0b dat=%0b, expected cyc=%0d addr=%02h w=%0b dat=%0b",
               nm, acyc, aaddr, aw, adat, e.cyc, e.addr, e.w, e.dat);
    end
  endfunction

  function automatic void unexp(string nm);
    tests++;
    fails++;
    $display("FAIL %s: unexpected assertion at cycle %0d, expected none", nm, cyc);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (a_gnt) begin
        if (q_ga.size() == 0) unexp("a_gnt");
        else begin e = q_ga.pop_front(); cmp("a_gnt", e, cyc, mem_addr, mem_w_nr, mem_w_nr ? mem_wdata : 2'b00); end
      end
      if (b_gnt) begin
        if (q_gb.size() == 0) unexp("b_gnt");
        else begin e = q_gb.pop_front(); cmp("b_gnt", e, cyc, mem_addr, mem_w_nr, mem_w_nr ? mem_wdata : 2'b00); end
      end
      if (a_rvalid) begin
        if (q_ra.size() == 0) unexp("a_rvalid");
        else begin e = q_ra.pop_front(); cmp("a_rvalid", e, cyc, e.addr, 1'b0, rdata); end
      end
      if (b_rvalid) begin
        if (q_rb.size() == 0) unexp("b_rvalid");
        else begin e = q_rb.pop_front(); cmp("b_rvalid", e, cyc, e.addr, 1'b0, rdata); end
      end
      if (clear_busy) begin
        if (q_cw.size() == 0) unexp("clear_wr");
        else begin e = q_cw.pop_front(); cmp("clear_wr", e, cyc, mem_addr, mem_w_nr, mem_wdata); end
      end
      if (clear_done) begin
        if (q_dn.size() == 0) unexp("clear_done");
        else begin e = q_dn.pop_front(); cmp("clear_done", e, cyc, 8'h00, 1'b0, 2'b00); end
      end
      if (!a_gnt && !b_gnt && !clear_busy) check("idle_w_nr", 32'(mem_w_nr), 32'd0);
    end
  end

  // One transaction on A (is_b=0) or B; lat = expected cycles from issue to grant.
  task automatic txn(input bit is_b, input logic [7:0] addr, input bit w,
                     input logic [1:0] wd, input logic [1:0] exp_rd, input int lat);
    exp_t e, r;
    bit   got;
    e.cyc = cyc + lat; e.addr = addr; e.w = w; e.dat = w ? wd : 2'b00;
    r.cyc = e.cyc + 1; r.addr = addr; r.w = 1'b0; r.dat = exp_rd;
    if (is_b) begin
      q_gb.push_back(e);
      if (!w) q_rb.push_back(r);
      b_req = 1'b1; b_addr = addr; b_w_nr = w; b_wdata = wd;
    end else begin
      q_ga.push_back(e);
      if (!w) q_ra.push_back(r);
      a_req = 1'b1; a_addr = addr; a_w_nr = w; a_wdata = wd;
    end
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      got = is_b ? b_gnt : a_gnt;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_gnt_timeout: got no grant, expected grant at cycle %0d", is_b ? "b" : "a", e.cyc);
    end
    if (is_b) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  // Pulse clear_req; expect nwr sweep writes and optionally the done pulse.
  task automatic clear_pulse(input int nwr, input bit exp_done);
    exp_t e;
    int   y, x;
    for (int k = 0; k < nwr; k++) begin
      y = k / 12;
      x = k % 12;
      e.cyc = cyc + 1 + k; e.addr = {y[3:0], x[3:0]}; e.w = 1'b1; e.dat = 2'b00;
      q_cw.push_back(e);
    end
    if (exp_done) begin
      e.cyc = cyc + 145; e.addr = 8'h00; e.w = 1'b0; e.dat = 2'b00;
      q_dn.push_back(e);
    end
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  task automatic check_reset_outs(input string nm);
    check(nm, 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, clear_busy, clear_done,
                   mem_w_nr, mem_addr, mem_wdata}), 32'd0);
  endtask

  initial begin
    rst = 1'b0; clear_req = 1'b0;
    a_req = 1'b0; a_addr = 8'h00; a_wdata = 2'b00; a_w_nr = 1'b0;
    b_req = 1'b0; b_addr = 8'h00; b_wdata = 2'b00; b_w_nr = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset_state");
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Both requesters held from reset: A wins the first tie, then strict alternation.
    fork
      begin
        txn(0, 8'h23, 0, 2'b00, 2'b10, 1);
        txn(0, 8'h11, 1, 2'b11, 2'b00, 2);
        txn(0, 8'h11, 0, 2'b00, 2'b11, 2);
        txn(0, 8'h45, 0, 2'b00, 2'b11, 2);
      end
      begin
        txn(1, 8'h45, 0, 2'b00, 2'b11, 2);
        txn(1, 8'h30, 1, 2'b01, 2'b00, 2);
        txn(1, 8'h30, 0, 2'b00, 2'b01, 2);
        txn(1, 8'h00, 0, 2'b00, 2'b00, 2);
      end
    join
    repeat (3) @(negedge clk);

    // Lone A read of the preloaded cell.
    txn(0, 8'h23, 0, 2'b00, 2'b10, 1);
    repeat (3) @(negedge clk);

    // B writes, A reads it back.
    txn(1, 8'h5B, 1, 2'b01, 2'b00, 1);
    txn(0, 8'h5B, 0, 2'b00, 2'b01, 1);
    repeat (3) @(negedge clk);

    // Clear wins over a pending A read; A is served after clear_done.
    fork
      clear_pulse(144, 1);
      txn(0, 8'h23, 0, 2'b00, 2'b00, 146);
    join
    repeat (2) @(negedge clk);
    txn(1, 8'h45, 0, 2'b00, 2'b00, 1);
    txn(0, 8'h5B, 0, 2'b00, 2'b00, 1);
    repeat (3) @(negedge clk);

    // Reset during sweep write 50 aborts it without clear_done.
    fork
      clear_pulse(50, 0);
      begin
        repeat (50) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outs("mid_sweep_reset");
        rst = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    clear_pulse(144, 1);
    repeat (150) @(negedge clk);

    // Second clear_req at write 10 is ignored.
    fork
      clear_pulse(144, 1);
      begin
        repeat (10) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
      end
    join
    repeat (145) @(negedge clk);

    check("q_a_gnt_left",    32'(q_ga.size()), 32'd0);
    check("q_b_gnt_left",    32'(q_gb.size()), 32'd0);
    check("q_a_rvalid_left", 32'(q_ra.size()), 32'd0);
    check("q_b_rvalid_left", 32'(q_rb.size()), 32'd0);
    check("q_clear_wr_left", 32'(q_cw.size()), 32'd0);
    check("q_clear_dn_left", 32'(q_dn.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
